// File: rtl/main_mem_responder_pkg.sv
// Shared types and helpers for the main-memory responder on the cache<->memory bus.
// Command decode and line-base address arithmetic live here so bus agents agree on them.
package main_mem_responder_pkg;

    localparam int DATA_W_C         = 32;
    localparam int WORDS_PER_LINE_C = 4;

    typedef enum logic [1:0] {CMD_NONE, CMD_RD, CMD_WR} bus_cmd_e;

    typedef enum logic [2:0] {IDLE, ACCESS, RBURST, WBURST, DONE} mem_state_e;

    // Both or neither of rd/wr is an illegal command.
    function automatic bus_cmd_e decode_cmd(input logic rd, input logic wr);
        if (rd && !wr) return CMD_RD;
        if (wr && !rd) return CMD_WR;
        return CMD_NONE;
    endfunction

    // Word address of the first word of the line holding byte_addr.
    function automatic logic [63:0] line_base(input logic [63:0] byte_addr,
                                              input int byte_sh, input int line_sh);
        return (byte_addr >> byte_sh) & ~((64'd1 << line_sh) - 64'd1);
    endfunction

endpackage

// File: rtl/main_mem_responder_mem_word_array.sv
// Single-port synchronous word storage: one-cycle read latency, write enable.
// No reset on the array; contents survive a bus reset.
module mem_word_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory end of the cache bus: serves line fills and line writebacks,
// with snoop intervention (bus_hitm) cancelling a fill during its access latency.
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = DATA_W_C,
    parameter int MEM_WORDS      = 1024,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_C,
    parameter int READ_LATENCY   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_rd,
    input  logic              bus_wr,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_hitm,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_wvalid,
    output logic              bus_wready,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    output logic              bus_done,
    output logic              bus_err
);

    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int LINE_SH = $clog2(WORDS_PER_LINE);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int LIDX_W  = IDX_W - LINE_SH;
    localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'(READ_LATENCY - 2);
    localparam logic [LINE_SH-1:0] BEAT_LAST = LINE_SH'(WORDS_PER_LINE - 1);

    mem_state_e         state;
    logic [LIDX_W-1:0]  line_idx;
    logic [LIDX_W-1:0]  req_line;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LINE_SH-1:0] beat;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_addr;
    logic [DATA_W-1:0]  mem_q;

    // Upper word-address bits beyond the storage depth alias away here.
    assign req_line = LIDX_W'(line_base(64'(bus_addr), BYTE_SH, LINE_SH) >> LINE_SH);

    assign mem_we = (state == WBURST) && bus_wvalid && bus_wready;

    // Reads run one word ahead: word 0 is addressed while waiting, so each
    // RBURST edge finds the current beat already on mem_q.
    always_comb begin
        mem_addr = {req_line, {LINE_SH{1'b0}}};
        case (state)
            ACCESS:  mem_addr = {line_idx, {LINE_SH{1'b0}}};
            RBURST:  mem_addr = {line_idx, beat + 1'b1};
            WBURST:  mem_addr = {line_idx, beat};
            default: ;
        endcase
    end

    mem_word_array #(
        .DEPTH (MEM_WORDS),
        .DATA_W(DATA_W)
    ) u_mem (
        .clock(clock),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(bus_wdata),
        .rdata(mem_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            line_idx   <= '0;
            lat_cnt    <= '0;
            beat       <= '0;
            bus_wready <= 1'b0;
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            bus_done   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            bus_done   <= 1'b0;
            bus_err    <= 1'b0;
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
            case (state)
                IDLE: begin
                    if (bus_req) begin
                        case (decode_cmd(bus_rd, bus_wr))
                            CMD_RD: begin
                                line_idx <= req_line;
                                lat_cnt  <= '0;
                                beat     <= '0;
                                state    <= (READ_LATENCY == 1) ? RBURST : ACCESS;
                            end
                            CMD_WR: begin
                                line_idx   <= req_line;
                                beat       <= '0;
                                bus_wready <= 1'b1;
                                state      <= WBURST;
                            end
                            default: bus_err <= 1'b1;
                        endcase
                    end
                end
                ACCESS: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (bus_hitm)
                        state <= DONE;
                    else if (lat_cnt == LAT_LAST)
                        state <= RBURST;
                end
                RBURST: begin
                    bus_rvalid <= 1'b1;
                    bus_rdata  <= mem_q;
                    beat       <= beat + 1'b1;
                    if (beat == BEAT_LAST) state <= DONE;
                end
                WBURST: begin
                    if (bus_wvalid) begin
                        beat <= beat + 1'b1;
                        if (beat == BEAT_LAST) begin
                            bus_wready <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: directed bus scenarios followed by randomized
// fills/writebacks checked against a word-array model of memory.
module tb_main_mem_responder;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 1024;
    localparam int WPL       = 4;
    localparam int RL        = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              bus_req = 1'b0, bus_rd = 1'b0, bus_wr = 1'b0;
    logic [ADDR_W-1:0] bus_addr = '0;
    logic              bus_hitm = 1'b0;
    logic [DATA_W-1:0] bus_wdata = '0;
    logic              bus_wvalid = 1'b0;
    logic              bus_wready;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid, bus_done, bus_err;

    always #5 clock = ~clock;

    main_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS),
        .WORDS_PER_LINE(WPL), .READ_LATENCY(RL)
    ) dut (
        .clock(clock), .reset(reset),
        .bus_req(bus_req), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_hitm(bus_hitm),
        .bus_wdata(bus_wdata), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .bus_done(bus_done), .bus_err(bus_err)
    );

    logic [DATA_W-1:0] model [MEM_WORDS];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // First word index of the addressed line, wrapped into storage depth.
    function automatic int line_word(input logic [31:0] addr);
        int unsigned w;
        w = addr / (DATA_W / 8);
        return int'((w - (w % WPL)) % MEM_WORDS);
    endfunction

    // mode 0: wvalid every cycle, 1: gap pattern 1,0,0,1,1,0,1, 2: random gaps
    task automatic do_write(input logic [31:0] addr, input logic [DATA_W-1:0] data [WPL],
                            input int mode, input string tag);
        int base, beats, cyc;
        logic v;
        logic [6:0] pat;
        pat = 7'b1011001;
        base = line_word(addr);
        beats = 0;
        cyc = 0;
        bus_req = 1'b1; bus_wr = 1'b1; bus_rd = 1'b0; bus_addr = addr;
        tick();
        while (beats < WPL && cyc < 64) begin
            check({tag, ".wready"}, 64'(bus_wready), 64'd1);
            check({tag, ".done_early"}, 64'(bus_done), 64'd0);
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = pat[cyc % 7];
            else v = (cyc >= 32) ? 1'b1 : 1'($urandom_range(0, 1));
            bus_wvalid = v;
            bus_wdata = v ? data[beats] : DATA_W'($urandom);
            tick();
            cyc++;
            if (v) begin
                model[base + beats] = data[beats];
                beats++;
            end
        end
        bus_wvalid = 1'b0;
        check({tag, ".beats"}, 64'(beats), 64'(WPL));
        check({tag, ".wready_off"}, 64'(bus_wready), 64'd0);
        check({tag, ".done_wait"}, 64'(bus_done), 64'd0);
        tick();
        check({tag, ".done"}, 64'(bus_done), 64'd1);
        bus_req = 1'b0; bus_wr = 1'b0;
        tick();
        check({tag, ".done_pulse"}, 64'(bus_done), 64'd0);
    endtask

    // rst_k > 0 asserts reset just after the k-th edge following accept.
    task automatic do_read(input logic [31:0] addr, input bit hitm, input bit noise,
                           input int rst_k, input string tag);
        int base, done_k;
        logic exp_v;
        logic [DATA_W-1:0] exp_d;
        base = line_word(addr);
        done_k = hitm ? 2 : RL + WPL;
        bus_req = 1'b1; bus_rd = 1'b1; bus_wr = 1'b0; bus_addr = addr;
        tick();
        bus_hitm = hitm;
        for (int k = 1; k <= done_k; k++) begin
            tick();
            bus_hitm = (noise && k >= RL - 1 && k < RL + WPL - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_v = !hitm && k >= RL && k < RL + WPL;
            exp_d = exp_v ? model[base + k - RL] : '0;
            check({tag, ".rvalid"}, 64'(bus_rvalid), 64'(exp_v));
            check({tag, ".rdata"}, 64'(bus_rdata), 64'(exp_d));
            check({tag, ".done"}, 64'(bus_done), 64'(k == done_k));
            if (k == rst_k) begin
                reset = 1'b1;
                #1;
                check({tag, ".rst_rvalid"}, 64'(bus_rvalid), 64'd0);
                check({tag, ".rst_rdata"}, 64'(bus_rdata), 64'd0);
                check({tag, ".rst_done"}, 64'(bus_done), 64'd0);
                bus_hitm = 1'b0;
                tick();
                reset = 1'b0; bus_req = 1'b0; bus_rd = 1'b0;
                tick();
                return;
            end
        end
        bus_hitm = 1'b0;
        bus_req = 1'b0; bus_rd = 1'b0;
        tick();
        check({tag, ".done_pulse"}, 64'(bus_done), 64'd0);
        check({tag, ".rvalid_off"}, 64'(bus_rvalid), 64'd0);
        check({tag, ".err"}, 64'(bus_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d [WPL];
        logic [31:0] a;

        // reset state
        tick();
        tick();
        check("rst.wready", 64'(bus_wready), 64'd0);
        check("rst.rvalid", 64'(bus_rvalid), 64'd0);
        check("rst.rdata", 64'(bus_rdata), 64'd0);
        check("rst.done", 64'(bus_done), 64'd0);
        check("rst.err", 64'(bus_err), 64'd0);
        reset = 1'b0;
        tick();

        // writeback then fill from another byte in the same line
        d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        do_write(32'h40, d, 0, "t1.wr");
        do_read(32'h44, 1'b0, 1'b0, 0, "t1.rd");

        // snoop intervention cancels the fill
        do_read(32'h40, 1'b1, 1'b0, 0, "t2.hitm");

        // illegal command
        bus_req = 1'b1; bus_rd = 1'b1; bus_wr = 1'b1; bus_addr = 32'h40;
        bus_wvalid = 1'b1; bus_wdata = 32'hDEADBEEF;
        tick();
        check("t3.err", 64'(bus_err), 64'd1);
        check("t3.done", 64'(bus_done), 64'd0);
        check("t3.wready", 64'(bus_wready), 64'd0);
        bus_req = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0; bus_wvalid = 1'b0;
        tick();
        check("t3.err_pulse", 64'(bus_err), 64'd0);
        do_read(32'h40, 1'b0, 1'b0, 0, "t3.rd");

        // reset during the second fill beat, then a clean refill
        do_read(32'h48, 1'b0, 1'b0, RL + 1, "t4.rst");
        do_read(32'h4C, 1'b0, 1'b0, 0, "t4.refill");

        // writeback with wvalid gaps
        d = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        do_write(32'h80, d, 1, "t5.wr");
        do_read(32'h8C, 1'b0, 1'b0, 0, "t5.rd");

        // address aliasing above storage depth
        do_read(MEM_WORDS * 4 + 32'h40, 1'b0, 1'b0, 0, "t6.alias");

        // randomized: fill lines 0..15 with known data, then mixed traffic
        for (int l = 0; l < 16; l++) begin
            for (int i = 0; i < WPL; i++) d[i] = DATA_W'($urandom);
            do_write(32'(l * 16 + $urandom_range(0, 15)), d, 2, "rnd.init");
        end
        for (int n = 0; n < 24; n++) begin
            a = 32'($urandom_range(0, 3) * MEM_WORDS * 4 + $urandom_range(0, 15) * 16
                    + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < WPL; i++) d[i] = DATA_W'($urandom);
                do_write(a, d, 2, "rnd.wr");
            end else begin
                do_read(a, $urandom_range(0, 3) == 0, 1'b1, 0, "rnd.rd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
